// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Holds the FSM state encoding, one-hot result codes and cascade resolution.
package cmp_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    // Result bits are ordered {gt, eq, lt} to match the agtb/aeqb/altb outputs.
    typedef enum logic [2:0] {
        ResNone = 3'b000,
        ResGt   = 3'b100,
        ResEq   = 3'b010,
        ResLt   = 3'b001
    } res_e;

    // Cascade priority: gt over lt over eq; nothing asserted resolves to equal.
    function automatic res_e resolve_cascade(input logic gt, input logic eq, input logic lt);
        res_e r;
        r = ResEq;
        if (eq) r = ResEq;
        if (lt) r = ResLt;
        if (gt) r = ResGt;
        return r;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one SLICE-bit slice.
// Exactly one of gt/eq/lt is asserted for any input pair.
module cmp_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] x_i,
    input  logic [SLICE-1:0] y_i,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);

    always_comb begin
        gt_o = 1'b0;
        eq_o = 1'b0;
        lt_o = 1'b0;
        if (x_i > y_i) begin
            gt_o = 1'b1;
        end else if (x_i < y_i) begin
            lt_o = 1'b1;
        end else begin
            eq_o = 1'b1;
        end
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle unsigned magnitude comparator: scans MSB-first one slice per cycle,
// stops on the first unequal slice, and resolves full equality from the cascade inputs.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_gt_i,
    input  logic             cin_eq_i,
    input  logic             cin_lt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             agtb_o,
    output logic             aeqb_o,
    output logic             altb_o,
    output logic             par_a_o,
    output logic             zero_a_o,
    output logic             ones_a_o
);

    localparam int unsigned NSL  = WIDTH / SLICE;
    localparam int unsigned IdxW = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(NSL - 1);

    state_e                      state_q;
    logic [NSL-1:0][SLICE-1:0]   a_q;
    logic [NSL-1:0][SLICE-1:0]   b_q;
    logic [2:0]                  cin_q;
    logic [IdxW-1:0]             idx_q;
    logic [2:0]                  res_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        par_q;
    logic                        zero_q;
    logic                        ones_q;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic             sl_gt;
    logic             sl_eq;
    logic             sl_lt;

    always_comb begin
        sl_a = a_q[idx_q];
        sl_b = b_q[idx_q];
    end

    cmp_slice #(
        .SLICE (SLICE)
    ) u_cmp_slice (
        .x_i  (sl_a),
        .y_i  (sl_b),
        .gt_o (sl_gt),
        .eq_o (sl_eq),
        .lt_o (sl_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 3'b000;
            idx_q   <= IdxTop;
            res_q   <= ResNone;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            par_q   <= 1'b0;
            zero_q  <= 1'b0;
            ones_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        cin_q   <= {cin_gt_i, cin_eq_i, cin_lt_i};
                        idx_q   <= IdxTop;
                        par_q   <= ^a_i;
                        zero_q  <= ~|a_i;
                        ones_q  <= &a_i;
                        busy_q  <= 1'b1;
                        state_q <= StScan;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StScan: begin
                    // start is deliberately not looked at here: in-flight ops are never disturbed.
                    if (!sl_eq) begin
                        res_q   <= sl_gt ? ResGt : ResLt;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (idx_q == '0) begin
                        res_q   <= resolve_cascade(cin_q[2], cin_q[1], cin_q[0]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q - IdxW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // sl_lt is implied by !sl_gt on an unequal slice; kept for symmetry of the slice unit.
    logic unused_lt;
    assign unused_lt = sl_lt;

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign agtb_o   = res_q[2];
    assign aeqb_o   = res_q[1];
    assign altb_o   = res_q[0];
    assign par_a_o  = par_q;
    assign zero_a_o = zero_q;
    assign ones_a_o = ones_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: directed table on a 32/4 unit, hand sequences for the
// multi-cycle corners, and a model-checked sweep over 32/4, 12/4 and 64/8 units.
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] bus_a = '0;
    logic [63:0] bus_b = '0;
    logic        cgt = 1'b0;
    logic        ceq = 1'b0;
    logic        clt = 1'b0;

    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] res0, res1, res2;
    logic [2:0] flg0, flg1, flg2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(32), .SLICE(4)) u_dut32 (
        .clk(clk), .rst(rst), .start_i(start), .a_i(bus_a[31:0]), .b_i(bus_b[31:0]),
        .cin_gt_i(cgt), .cin_eq_i(ceq), .cin_lt_i(clt),
        .busy_o(busy[0]), .done_o(done[0]),
        .agtb_o(res0[2]), .aeqb_o(res0[1]), .altb_o(res0[0]),
        .par_a_o(flg0[2]), .zero_a_o(flg0[1]), .ones_a_o(flg0[0])
    );

    seq_magnitude_comparator #(.WIDTH(12), .SLICE(4)) u_dut12 (
        .clk(clk), .rst(rst), .start_i(start), .a_i(bus_a[11:0]), .b_i(bus_b[11:0]),
        .cin_gt_i(cgt), .cin_eq_i(ceq), .cin_lt_i(clt),
        .busy_o(busy[1]), .done_o(done[1]),
        .agtb_o(res1[2]), .aeqb_o(res1[1]), .altb_o(res1[0]),
        .par_a_o(flg1[2]), .zero_a_o(flg1[1]), .ones_a_o(flg1[0])
    );

    seq_magnitude_comparator #(.WIDTH(64), .SLICE(8)) u_dut64 (
        .clk(clk), .rst(rst), .start_i(start), .a_i(bus_a), .b_i(bus_b),
        .cin_gt_i(cgt), .cin_eq_i(ceq), .cin_lt_i(clt),
        .busy_o(busy[2]), .done_o(done[2]),
        .agtb_o(res2[2]), .aeqb_o(res2[1]), .altb_o(res2[0]),
        .par_a_o(flg2[2]), .zero_a_o(flg2[1]), .ones_a_o(flg2[0])
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cin;  // {gt, eq, lt}
        logic [2:0]  res;  // {agtb, aeqb, altb}
        int          lat;  // edges from accepting edge (inclusive) to done
        logic [2:0]  flg;  // {par_a, zero_a, ones_a}
    } vec_t;

    localparam int NV = 10;
    vec_t vt[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one request; returns #1 after the accepting edge.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] cin);
        @(negedge clk);
        bus_a = a;
        bus_b = b;
        {cgt, ceq, clt} = cin;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Records, per unit, the edge count at which done is first seen; 0 means timeout.
    task automatic wait_done(input int n0, output int l0, output int l1, output int l2);
        int n;
        n  = n0;
        l0 = 0;
        l1 = 0;
        l2 = 0;
        while ((l0 == 0 || l1 == 0 || l2 == 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done[0] && l0 == 0) l0 = n;
            if (done[1] && l1 == 0) l1 = n;
            if (done[2] && l2 == 0) l2 = n;
        end
    endtask

    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] cin, input int w, input int s,
                                  output logic [2:0] res, output int lat,
                                  output logic [2:0] flg);
        logic [63:0] mask, am, bm, diff;
        int          h;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        if (am > bm)      res = 3'b100;
        else if (am < bm) res = 3'b001;
        else if (cin[2])  res = 3'b100;
        else if (cin[0])  res = 3'b001;
        else              res = 3'b010;
        diff = am ^ bm;
        h = -1;
        for (int i = 0; i < w; i++) if (diff[i]) h = i;
        lat = (h < 0) ? (w / s + 1) : (w / s - h / s + 1);
        flg = {^am, am == 64'd0, am == mask};
    endfunction

    initial begin
        int          l0, l1, l2, lat;
        logic [2:0]  er;
        logic [2:0]  ef;
        logic        saw_done;
        logic [63:0] ra, rb;
        logic [2:0]  rc;

        vt[0] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b000, 3'b100, 2, 3'b100};
        vt[1] = '{32'h1234_5678, 32'h1234_5678, 3'b001, 3'b001, 9, 3'b100};
        vt[2] = '{32'h1234_5678, 32'h1234_5678, 3'b000, 3'b010, 9, 3'b100};
        vt[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b100, 3'b100, 9, 3'b001};
        vt[4] = '{32'h0000_0000, 32'h0000_0001, 3'b000, 3'b001, 9, 3'b010};
        vt[5] = '{32'h0000_00F0, 32'h0000_0F00, 3'b000, 3'b001, 7, 3'b000};
        vt[6] = '{32'h0000_0000, 32'h0000_0000, 3'b101, 3'b100, 9, 3'b010};
        vt[7] = '{32'h0000_0005, 32'h0000_0005, 3'b011, 3'b001, 9, 3'b000};
        vt[8] = '{32'hA000_0000, 32'h5000_0000, 3'b000, 3'b100, 2, 3'b000};
        vt[9] = '{32'hCAFE_0001, 32'hCAFE_0001, 3'b010, 3'b010, 9, 3'b000};

        #3;
        chk("reset outputs", {busy, done, res0, res1, res2, flg0, flg1, flg2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            start_op({32'd0, vt[i].a}, {32'd0, vt[i].b}, vt[i].cin);
            chk($sformatf("v%0d busy", i), {62'd0, busy[0], done[0]}, 64'd2);
            wait_done(1, l0, l1, l2);
            chk($sformatf("v%0d latency", i), l0, vt[i].lat);
            chk($sformatf("v%0d result", i), res0, vt[i].res);
            chk($sformatf("v%0d flags", i), flg0, vt[i].flg);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done pulse/hold", i), {busy[0], done[0], res0}, {2'b00, vt[i].res});
        end

        // start during SCAN is ignored; start during the done cycle is accepted.
        start_op(64'h1234_5678, 64'h1234_5678, 3'b000);
        @(negedge clk);
        bus_a = 64'hFFFF_FFFF;
        bus_b = 64'h0;
        cgt   = 1'b0;
        clt   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(2, l0, l1, l2);
        chk("ignored start latency", l0, 9);
        chk("ignored start result", {res0, flg0}, {3'b010, 3'b100});
        start_op(64'h1000_0000, 64'h2, 3'b001);
        chk("back-to-back busy", {busy[0], done[0]}, 2'b10);
        wait_done(1, l0, l1, l2);
        chk("back-to-back latency", l0, 2);
        chk("back-to-back result", {res0, flg0}, {3'b100, 3'b100});

        // Asynchronous reset in the third SCAN cycle aborts without a done.
        start_op(64'h1234_5678, 64'h1234_5678, 3'b000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async reset outputs", {busy, done, res0, res1, res2, flg0, flg1, flg2}, 64'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 saw_done = saw_done | (|done);
        end
        chk("no done under reset", saw_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start_op(64'h0, 64'h1, 3'b000);
        wait_done(1, l0, l1, l2);
        chk("post-reset latency", l0, 9);
        chk("post-reset result", {res0, flg0}, {3'b001, 3'b010});

        for (int i = 0; i < 1500; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case (i % 4)
                1: rb = ra;
                2: rb = ra ^ (64'd1 << $urandom_range(63, 0));
                3: rb = ra ^ (64'd1 << $urandom_range(11, 0));
                default: ;
            endcase
            rc = 3'($urandom_range(7, 0));
            start_op(ra, rb, rc);
            wait_done(1, l0, l1, l2);
            model(ra, rb, rc, 32, 4, er, lat, ef);
            chk($sformatf("sweep32 #%0d", i), {res0, flg0, 32'(l0)}, {er, ef, 32'(lat)});
            model(ra, rb, rc, 12, 4, er, lat, ef);
            chk($sformatf("sweep12 #%0d", i), {res1, flg1, 32'(l1)}, {er, ef, 32'(lat)});
            model(ra, rb, rc, 64, 8, er, lat, ef);
            chk($sformatf("sweep64 #%0d", i), {res2, flg2, 32'(l2)}, {er, ef, 32'(lat)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
